// File: rtl/sat_round_pipe.sv
// Round-and-saturate stage: CH signed N-bit samples -> signed K-bit samples, F LSBs dropped.
// Latency: 2 cycles from accepted input to o_valid; throughput 1 vector/cycle.
// Backpressure: single global enable, o_ready = ~o_valid | i_ready; a stall freezes both stages.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready   input handshake; i_data carries CH packed N-bit samples,
//                       with i_round_mode and i_wrap captured alongside the samples
//   o_valid / i_ready   output handshake; o_data carries CH packed K-bit samples,
//                       o_ovf flags the channels that saturated or wrapped
//   i_clr_sticky        synchronous clear of o_ovf_sticky and o_ovf_count
//   o_ovf_sticky        per-channel overflow history
//   o_ovf_count         number of output vectors with any overflow, saturating at all-ones
module sat_round_pipe #(
    parameter int N     = 16,
    parameter int K     = 8,
    parameter int F     = 4,
    parameter int CH    = 1,
    parameter int CNT_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [CH*N-1:0]     i_data,
    input  logic [1:0]          i_round_mode,
    input  logic                i_wrap,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [CH*K-1:0]     o_data,
    output logic [CH-1:0]       o_ovf,
    input  logic                i_clr_sticky,
    output logic [CH-1:0]       o_ovf_sticky,
    output logic [CNT_W-1:0]    o_ovf_count
);

    // Rounded intermediate width: one extra sign bit so q + 1 can never wrap.
    localparam int M = N - F + 1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Global advance
    // ------------------------------------------------------------------
    logic en;

    assign en      = ~o_valid | i_ready;
    assign o_ready = en;

    // ------------------------------------------------------------------
    // Stage 1: rounding (combinational part)
    // ------------------------------------------------------------------
    logic [CH-1:0][M-1:0] rnd;

    for (genvar c = 0; c < CH; c++) begin : g_rnd
        logic [N-1:0] x;
        logic [M-1:0] q;
        logic         r;
        logic         s;
        logic         inc;

        assign x = i_data[c*N +: N];

        // Floor of x / 2^F, sign-extended by one bit.
        assign q = {x[N-1], x[N-1:F]};

        // r is the half-LSB, s is "anything below the half-LSB".
        if (F == 0) begin : g_f0
            assign r = 1'b0;
            assign s = 1'b0;
        end else if (F == 1) begin : g_f1
            assign r = x[0];
            assign s = 1'b0;
        end else begin : g_fn
            assign r = x[F-1];
            assign s = |x[F-2:0];
        end

        always_comb begin
            inc = 1'b0;
            case (i_round_mode)
                2'b01:   inc = r;
                // Ties go to the even neighbour: bump only past the half,
                // or exactly at the half when q is odd.
                2'b10:   inc = r & (s | q[0]);
                default: inc = 1'b0;
            endcase
        end

        assign rnd[c] = q + {{(M-1){1'b0}}, inc};
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic                 s1_vld;
    logic                 s1_wrap;
    logic [CH-1:0][M-1:0] s1_val;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld  <= 1'b0;
            s1_wrap <= 1'b0;
            s1_val  <= '0;
        end else if (en) begin
            s1_vld  <= i_valid;
            s1_wrap <= i_wrap;
            s1_val  <= rnd;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturate / wrap (combinational part)
    // ------------------------------------------------------------------
    logic [CH-1:0][K-1:0] sat;
    logic [CH-1:0]        ovf;

    for (genvar c = 0; c < CH; c++) begin : g_sat
        logic [M-1:0] v;

        assign v = s1_val[c];

        if (M < K) begin : g_ext
            assign ovf[c] = 1'b0;
            assign sat[c] = {{(K-M){v[M-1]}}, v};
        end else if (M == K) begin : g_eq
            assign ovf[c] = 1'b0;
            assign sat[c] = v;
        end else begin : g_chk
            // v fits in K signed bits exactly when bits [M-1:K-1] are all
            // copies of the sign; anything else is above MAX or below MIN.
            logic [M-K:0] top;

            assign top    = v[M-1:K-1];
            assign ovf[c] = ~((&top) | ~(|top));
            assign sat[c] = (ovf[c] & ~s1_wrap) ? {v[M-1], {(K-1){~v[M-1]}}}
                                                : v[K-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ovf   <= '0;
        end else if (en) begin
            o_valid <= s1_vld;
            o_data  <= sat;
            // Bubbles carry no overflow so o_ovf never flags a non-vector.
            o_ovf   <= s1_vld ? ovf : '0;
        end
    end

    // ------------------------------------------------------------------
    // Overflow statistics
    // ------------------------------------------------------------------
    logic load;
    logic any_ovf;

    assign load    = en & s1_vld;
    assign any_ovf = |ovf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ovf_sticky <= '0;
            o_ovf_count  <= '0;
        end else if (load) begin
            if (i_clr_sticky) begin
                // The event landing in the clear cycle still gets recorded.
                o_ovf_sticky <= ovf;
                o_ovf_count  <= any_ovf ? CNT_ONE : '0;
            end else begin
                o_ovf_sticky <= o_ovf_sticky | ovf;
                if (any_ovf && (o_ovf_count != {CNT_W{1'b1}})) begin
                    o_ovf_count <= o_ovf_count + CNT_ONE;
                end
            end
        end else if (i_clr_sticky) begin
            o_ovf_sticky <= '0;
            o_ovf_count  <= '0;
        end
    end

endmodule
